// File: rtl/d_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// d_hazard_ctrl
//
// Purpose:
//   Hazard and stall sequencer for the 5-stage MIPS pipeline. It drives the
//   stage-register enables and bubble controls. It detects load-use hazards,
//   freezes the pipeline while data memory is not ready, and flushes IF/ID on
//   taken branches. A memory access that stays not-ready for too long sends
//   the block into a sticky HALT, which only reset can clear.
//
// Parameters:
//   MEM_TIMEOUT  not-ready cycles tolerated before HALT (must be >= 2)
//   CNT_W        width of the stall performance counter
//
// Optional feature (macro HZ_PERF_CNT_EN):
//   If defined, o_hz_stall_cnt is a saturating count of stall cycles.
//   If undefined, no counter flops are built and o_hz_stall_cnt is tied to 0.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_hz_id_rs/_id_rt     source register fields of the instruction in ID
//   i_hz_ex_rt            destination rt of the instruction in EX
//   i_hz_ex_memread       the instruction in EX is a load
//   i_hz_mem_req          the MEM stage holds a load or store
//   i_hz_mem_ready        data memory completes the access this cycle
//   i_hz_branch_taken     EX resolved a taken branch
//   o_hz_pc_en            PC update enable
//   o_hz_ifid_en          IF/ID register enable
//   o_hz_ifid_flush       clear IF/ID to NOP
//   o_hz_idex_bubble      zero all ID/EX control bits
//   o_hz_exmem_en         ID/EX and EX/MEM register enable
//   o_hz_memwb_bubble     zero MEM/WB regwrite
//   o_hz_mem_err          sticky memory-timeout flag
//   o_hz_stall_cnt        total stall cycles (saturating)
// ---------------------------------------------------------------------------
module d_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_hz_id_rs,
  input  logic [4:0]       i_hz_id_rt,
  input  logic [4:0]       i_hz_ex_rt,
  input  logic             i_hz_ex_memread,
  input  logic             i_hz_mem_req,
  input  logic             i_hz_mem_ready,
  input  logic             i_hz_branch_taken,
  output logic             o_hz_pc_en,
  output logic             o_hz_ifid_en,
  output logic             o_hz_ifid_flush,
  output logic             o_hz_idex_bubble,
  output logic             o_hz_exmem_en,
  output logic             o_hz_memwb_bubble,
  output logic             o_hz_mem_err,
  output logic [CNT_W-1:0] o_hz_stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam int                WCNT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [WCNT_W-1:0] w_wait_cnt_nxt;
  logic              w_load_use;
  logic              w_eval_events;

  // A load in EX whose destination feeds the instruction in ID. Register 0 is
  // never a real dependency, because it is hard-wired to zero.
  assign w_load_use = i_hz_ex_memread && (i_hz_ex_rt != 5'd0) &&
                      ((i_hz_ex_rt == i_hz_id_rs) || (i_hz_ex_rt == i_hz_id_rt));

  // Branch and load-use are examined only when the pipeline moves this cycle.
  // That is RUN without a memory wait, or the MWAIT cycle that releases. A
  // frozen event is therefore picked up again on release, not lost.
  assign w_eval_events = ((r_state == RUN)   && !(i_hz_mem_req && !i_hz_mem_ready)) ||
                         ((r_state == MWAIT) && i_hz_mem_ready);

  // State and wait counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next-state logic and outputs.
  // Priority in a moving cycle is: memory wait, then taken branch, then
  // load-use. Holding reset overrides everything with the reset output pattern.
  always_comb begin
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    o_hz_pc_en        = 1'b1;
    o_hz_ifid_en      = 1'b1;
    o_hz_ifid_flush   = 1'b0;
    o_hz_idex_bubble  = 1'b0;
    o_hz_exmem_en     = 1'b1;
    o_hz_memwb_bubble = 1'b0;
    o_hz_mem_err      = 1'b0;

    case (r_state)
      RUN: begin
        if (i_hz_mem_req && !i_hz_mem_ready) begin
          o_hz_pc_en        = 1'b0;
          o_hz_ifid_en      = 1'b0;
          o_hz_exmem_en     = 1'b0;
          o_hz_memwb_bubble = 1'b1;
          w_state_nxt       = MWAIT;
          w_wait_cnt_nxt    = WCNT_W'(1);
        end
      end
      MWAIT: begin
        if (!i_hz_mem_ready) begin
          o_hz_pc_en        = 1'b0;
          o_hz_ifid_en      = 1'b0;
          o_hz_exmem_en     = 1'b0;
          o_hz_memwb_bubble = 1'b1;
          w_wait_cnt_nxt    = r_wait_cnt + WCNT_W'(1);
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt = HALT;
          end
        end else begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end
      end
      HALT: begin
        o_hz_pc_en        = 1'b0;
        o_hz_ifid_en      = 1'b0;
        o_hz_exmem_en     = 1'b0;
        o_hz_idex_bubble  = 1'b1;
        o_hz_memwb_bubble = 1'b1;
        o_hz_mem_err      = 1'b1;
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase

    if (w_eval_events) begin
      if (i_hz_branch_taken) begin
        o_hz_ifid_flush  = 1'b1;
        o_hz_idex_bubble = 1'b1;
      end else if (w_load_use) begin
        // The load moves to MEM next cycle, so one bubble is enough.
        o_hz_pc_en       = 1'b0;
        o_hz_ifid_en     = 1'b0;
        o_hz_idex_bubble = 1'b1;
      end
    end

    if (!i_rst_n) begin
      o_hz_pc_en        = 1'b0;
      o_hz_ifid_en      = 1'b0;
      o_hz_exmem_en     = 1'b0;
      o_hz_ifid_flush   = 1'b1;
      o_hz_idex_bubble  = 1'b1;
      o_hz_memwb_bubble = 1'b1;
      o_hz_mem_err      = 1'b0;
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating stall counter. It counts every cycle that holds the PC, except
  // cycles in HALT. The counter does not run while reset is held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (!o_hz_pc_en && (r_state != HALT) && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_hz_stall_cnt = r_stall_cnt;
`else
  assign o_hz_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_d_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_d_hazard_ctrl
//
// Directed bench for d_hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
// The control outputs are packed as
//   {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble, mem_err}
// and compared against hand-written patterns. The expected stall count comes
// from a running count of stall cycles. It saturates at 15 when
// HZ_PERF_CNT_EN is defined, and is 0 otherwise.
// ---------------------------------------------------------------------------
module tb_d_hazard_ctrl;

  localparam logic [6:0] RUN_DEF  = 7'b1100100;
  localparam logic [6:0] RST_VAL  = 7'b0011010;
  localparam logic [6:0] FREEZE   = 7'b0000010;
  localparam logic [6:0] BRANCH   = 7'b1111100;
  localparam logic [6:0] LOADUSE  = 7'b0001100;
  localparam logic [6:0] HALT_VAL = 7'b0001011;

  logic       clk;
  logic       rstN;
  logic [4:0] idRs, idRt, exRt;
  logic       exMemread, memReq, memReady, branchTaken;
  logic       pcEn, ifidEn, ifidFlush, idexBubble, exmemEn, memwbBubble, memErr;
  logic [3:0] stallCnt;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  d_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .i_clk             (clk),
    .i_rst_n           (rstN),
    .i_hz_id_rs        (idRs),
    .i_hz_id_rt        (idRt),
    .i_hz_ex_rt        (exRt),
    .i_hz_ex_memread   (exMemread),
    .i_hz_mem_req      (memReq),
    .i_hz_mem_ready    (memReady),
    .i_hz_branch_taken (branchTaken),
    .o_hz_pc_en        (pcEn),
    .o_hz_ifid_en      (ifidEn),
    .o_hz_ifid_flush   (ifidFlush),
    .o_hz_idex_bubble  (idexBubble),
    .o_hz_exmem_en     (exmemEn),
    .o_hz_memwb_bubble (memwbBubble),
    .o_hz_mem_err      (memErr),
    .o_hz_stall_cnt    (stallCnt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected stall counter value after n counted stall cycles.
  function automatic logic [3:0] expCnt(input int n);
`ifdef HZ_PERF_CNT_EN
    return (n > 15) ? 4'd15 : 4'(n);
`else
    return 4'd0;
`endif
  endfunction

  // Drive one cycle's inputs and let the combinational outputs settle.
  task automatic applyStimulus(input logic rd, input logic [4:0] rt, input logic [4:0] rs,
                               input logic [4:0] idrt, input logic req, input logic rdy,
                               input logic br);
    exMemread   = rd;
    exRt        = rt;
    idRs        = rs;
    idRt        = idrt;
    memReq      = req;
    memReady    = rdy;
    branchTaken = br;
    #1;
  endtask

  // Compare the packed control outputs. A cycle that holds the PC outside
  // reset and HALT adds to the expected stall count.
  task automatic checkOutput(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {pcEn, ifidEn, ifidFlush, idexBubble, exmemEn, memwbBubble, memErr};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    if (rstN && !exp[6] && !exp[0]) stalls++;
  endtask

  // Compare the stall counter against the running model count.
  task automatic checkCnt(input string tag);
    logic [3:0] exp;
    exp = expCnt(stalls);
    checks++;
    assert (stallCnt === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, stallCnt, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    rstN = 1'b0;
    stalls = 0;
    tick();
    rstN = 1'b1;
  endtask

  // Directed sequence.
  initial begin
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    $display("[TB] reset");
    checkOutput("reset_outputs", RST_VAL);
    checkCnt("reset_cnt");
    tick();
    rstN = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("run_default", RUN_DEF);
    tick();

    $display("[TB] load-use");
    applyStimulus(1, 5, 5, 0, 0, 0, 0);
    checkOutput("loaduse_rs", LOADUSE);
    tick();
    applyStimulus(0, 0, 5, 0, 0, 0, 0);
    checkOutput("loaduse_after", RUN_DEF);
    checkCnt("loaduse_cnt");
    tick();
    applyStimulus(1, 7, 3, 7, 0, 0, 0);
    checkOutput("loaduse_rt", LOADUSE);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("loaduse_r0", RUN_DEF);
    tick();
    applyStimulus(0, 5, 5, 5, 0, 0, 0);
    checkOutput("no_memread", RUN_DEF);
    tick();
    applyStimulus(1, 6, 5, 7, 0, 0, 0);
    checkOutput("no_match", RUN_DEF);
    tick();

    $display("[TB] memory wait");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("mwait_freeze", FREEZE);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("mwait_release", RUN_DEF);
    checkCnt("mwait_cnt");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("mwait_back_run", RUN_DEF);
    tick();

    $display("[TB] priority");
    applyStimulus(1, 5, 5, 0, 1, 0, 1);
    checkOutput("prio_freeze", FREEZE);
    tick();
    applyStimulus(1, 5, 5, 0, 1, 1, 1);
    checkOutput("prio_release_branch", BRANCH);
    tick();
    applyStimulus(1, 5, 5, 0, 0, 0, 1);
    checkOutput("branch_over_loaduse", BRANCH);
    tick();
    applyStimulus(1, 9, 0, 9, 1, 0, 0);
    checkOutput("loaduse_frozen", FREEZE);
    tick();
    applyStimulus(1, 9, 0, 9, 1, 1, 0);
    checkOutput("loaduse_on_release", LOADUSE);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("prio_done", RUN_DEF);
    checkCnt("prio_cnt");
    tick();

    $display("[TB] reset mid-wait");
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("rstwait_freeze0", FREEZE);
    tick();
    checkOutput("rstwait_freeze1", FREEZE);
    #2;
    rstN = 1'b0;
    stalls = 0;
    #1;
    checkOutput("rstwait_async", RST_VAL);
    checkCnt("rstwait_cnt");
    tick();
    rstN = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rstwait_run", RUN_DEF);
    checkCnt("rstwait_cnt_after");
    tick();

    $display("[TB] timeout");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("timeout_freeze", FREEZE);
      tick();
    end
    checkOutput("halt_entered", HALT_VAL);
    checkCnt("halt_cnt");
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    checkOutput("halt_sticky_ready", HALT_VAL);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_sticky_idle", HALT_VAL);
    checkCnt("halt_cnt_frozen");
    tick();
    resetPulse();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_cleared", RUN_DEF);
    checkCnt("halt_cleared_cnt");
    tick();

    $display("[TB] saturation");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 4, 4, 0, 0, 0, 0);
      checkOutput("sat_loaduse", LOADUSE);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_done", RUN_DEF);
    checkCnt("sat_cnt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_hazard_ctrl.md
Name: d_hazard_ctrl

Overview:
- Pipeline hazard and stall sequencer for the 5-stage MIPS core; sits beside decode control and drives the stage-register enables and bubble controls.
- Detects load-use hazards, freezes the pipeline while data memory is not ready, and flushes on taken branches.
- Escalates to a sticky halt when a memory access exceeds a timeout.

Parameters:
- MEM_TIMEOUT, 16, max consecutive not-ready cycles tolerated before entering HALT (must be >= 2)
- CNT_W, 16, width of the stall performance counter

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_hz_id_rs  in  5  rs field of the instruction in ID
- i_hz_id_rt  in  5  rt field of the instruction in ID
- i_hz_ex_rt  in  5  destination rt of the instruction in EX
- i_hz_ex_memread  in  1  EX instruction is a load (memread)
- i_hz_mem_req  in  1  MEM stage holds a load or store
- i_hz_mem_ready  in  1  data memory completes the access this cycle
- i_hz_branch_taken  in  1  EX resolved a taken branch
- o_hz_pc_en  out  1  PC update enable
- o_hz_ifid_en  out  1  IF/ID register enable
- o_hz_ifid_flush  out  1  clear IF/ID to NOP
- o_hz_idex_bubble  out  1  zero all ID/EX control bits (regwrite, memread, memwrite, memtoreg, aluop, other)
- o_hz_exmem_en  out  1  ID/EX and EX/MEM register enable
- o_hz_memwb_bubble  out  1  zero MEM/WB regwrite
- o_hz_mem_err  out  1  sticky timeout flag
- o_hz_stall_cnt  out  CNT_W  total stall cycles

Behaviour:
- State register: RUN, MWAIT, HALT. Outputs are combinational from state and inputs; state, wait counter and stall counter are registered.
- Reset (i_rst_n=0, asynchronous):
  - state=RUN, wait counter=0, o_hz_mem_err=0, o_hz_stall_cnt=0.
  - Outputs are forced while reset is held: pc_en=0, ifid_en=0, exmem_en=0, ifid_flush=1, idex_bubble=1, memwb_bubble=1.
- Default outputs in RUN with no event: pc_en=1, ifid_en=1, exmem_en=1, all bubbles, flush and err=0.
- Priority within RUN: memory wait > taken branch > load-use.
- Memory wait (RUN, mem_req=1, mem_ready=0):
  - Freeze this cycle: pc_en=ifid_en=exmem_en=0, memwb_bubble=1.
  - Next state MWAIT, wait counter=1.
- MWAIT:
  - mem_ready=0: freeze as above and increment the wait counter. If the counter equals MEM_TIMEOUT-1 at the clock edge, the next state is HALT.
  - mem_ready=1: no freeze this cycle, next state RUN, wait counter cleared. Branch and load-use are evaluated normally in this release cycle.
- Taken branch (RUN, no memory wait): ifid_flush=1 and idex_bubble=1 for one cycle; pc_en=1 loads the target.
- Load-use (RUN, no memory wait, no branch):
  - Condition: ex_memread=1, ex_rt!=0, and ex_rt==id_rs or ex_rt==id_rt.
  - Action: pc_en=0, ifid_en=0, idex_bubble=1; exmem_en stays 1.
  - Exactly one bubble, because the load advances to MEM on the next cycle.
- A branch or load-use coinciding with a memory wait is not lost: the frozen stages hold their inputs, so the event is re-evaluated on release.
- HALT:
  - o_hz_mem_err=1, all enables 0, idex_bubble=1, memwb_bubble=1.
  - Exit only by reset. mem_ready is ignored.
- Stall counter: +1 on every cycle with pc_en=0 outside reset and outside HALT; saturates at all-ones, no wrap.
- Reset asserted mid-MWAIT: immediate return to RUN with counters cleared; the pending access is abandoned.

Optional Feature:
- Macro: HZ_PERF_CNT_EN.
- Defined: the stall counter is implemented as above.
- Undefined: no counter flops; o_hz_stall_cnt is tied to 0.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then RUN defaults; repeat with ex_rt=0 -> no stall.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> pc_en=exmem_en=0 and memwb_bubble=1 for exactly 3 cycles; stall_cnt +3; state back to RUN.
- Priority: branch_taken=1 with mem_req=1, mem_ready=0 -> freeze only, no flush; on release -> ifid_flush=1 and idex_bubble=1 for one cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> HALT after 4 frozen cycles, mem_err=1 sticky; later mem_ready=1 has no effect until i_rst_n pulse clears it.
- Reset mid-wait: drop i_rst_n during MWAIT -> outputs forced to reset values asynchronously, stall_cnt=0; after release, RUN defaults.
- Saturation: with HZ_PERF_CNT_EN and CNT_W=4, 20 stall cycles -> stall_cnt=15; without the macro -> stall_cnt=0.
